alu_preproc_pipe: RTL

Pipelined, parametrised operand preprocessor for the ALU adder path. It takes two operands and an operation code, sign- or zero-extends them to the datapath width, and produces the adder operands (`a_mod_o`, `b_mod_o`) plus carry-in. Results are registered behind a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between instruction issue and the ripple/carry-lookahead adder, replacing the fixed 4-bit combinational preprocessor.

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/skid_buffer.sv | 77 +++++++
 rtl/alu_preproc_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes and the adder-operand preprocessing decode.
// The decode works at a fixed maximum width; callers zero-pad inputs and keep the low bits.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_NEG  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_CMP  = 3'b110,
        OP_ILL  = 3'b111
    } op_t;

    localparam int unsigned PP_MAX_W = 64;

    typedef struct packed {
        logic [PP_MAX_W-1:0] a_mod;
        logic [PP_MAX_W-1:0] b_mod;
        logic                cin;
        logic                cmp;
        logic                ill;
    } pp_t;

    // Inversions set the padded upper bits too; they are dropped by the caller's truncation.
    function automatic pp_t preproc_decode(input op_t op,
                                           input logic [PP_MAX_W-1:0] a,
                                           input logic [PP_MAX_W-1:0] b);
        pp_t r;
        r = '0;
        case (op)
            OP_PASS: begin
                r.a_mod = a;
            end
            OP_NEG: begin
                r.b_mod = ~a;
                r.cin   = 1'b1;
            end
            OP_ADD: begin
                r.a_mod = a;
                r.b_mod = b;
            end
            OP_SUB: begin
                r.a_mod = a;
                r.b_mod = ~b;
                r.cin   = 1'b1;
            end
            OP_INC: begin
                r.a_mod = a;
                r.cin   = 1'b1;
            end
            OP_DEC: begin
                r.a_mod = a;
                r.b_mod = {PP_MAX_W{1'b1}};
            end
            OP_CMP: begin
                r.a_mod = a;
                r.b_mod = ~b;
                r.cin   = 1'b1;
                r.cmp   = 1'b1;
            end
            default: begin
                r.a_mod = a;
                r.ill   = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic two-entry valid/ready buffer: an output register plus one skid register.
// Ready depends only on the skid register, so there is no combinational ready path.
module skid_buffer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          r_out_valid;
    logic          r_skid_valid;
    logic [DW-1:0] r_out_data;
    logic [DW-1:0] r_skid_data;
    logic          w_out_valid_nx;
    logic          w_skid_valid_nx;
    logic [DW-1:0] w_out_data_nx;
    logic [DW-1:0] w_skid_data_nx;
    logic          w_in_fire;
    logic          w_out_fire;

    assign w_in_fire  = in_valid_i & ~r_skid_valid;
    assign w_out_fire = r_out_valid & out_ready_i;

    // Next-state: refill from skid first; new data only lands in skid when output is held.
    always_comb begin
        w_out_valid_nx  = r_out_valid;
        w_skid_valid_nx = r_skid_valid;
        w_out_data_nx   = r_out_data;
        w_skid_data_nx  = r_skid_data;
        if (w_out_fire) begin
            if (r_skid_valid) begin
                w_out_data_nx   = r_skid_data;
                w_skid_valid_nx = 1'b0;
            end else if (w_in_fire) begin
                w_out_data_nx   = in_data_i;
            end else begin
                w_out_valid_nx  = 1'b0;
            end
        end else if (w_in_fire) begin
            if (r_out_valid) begin
                w_skid_valid_nx = 1'b1;
                w_skid_data_nx  = in_data_i;
            end else begin
                w_out_valid_nx  = 1'b1;
                w_out_data_nx   = in_data_i;
            end
        end else begin
            w_out_valid_nx = r_out_valid;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_out_data   <= w_out_data_nx;
            r_skid_data  <= w_skid_data_nx;
        end
    end

    assign in_ready_o  = ~r_skid_valid;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;

endmodule

// File: rtl/alu_preproc_pipe.sv
// Pipelined adder-operand preprocessor: extend, decode, buffer, plus sticky
// illegal-op flag and completed-transfer counter. WIDTH must not exceed alu_pkg::PP_MAX_W.
module alu_preproc_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic [2:0]       op_i,
    input  logic             sext_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] a_mod_o,
    output logic [WIDTH-1:0] b_mod_o,
    output logic             cin_o,
    output logic             cmp_o,
    output logic             err_o,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] op_cnt_o
);

    localparam int DW = 2 * WIDTH + 2;

    logic signed [WIDTH-1:0] w_a_sx;
    logic signed [WIDTH-1:0] w_b_sx;
    logic        [WIDTH-1:0] w_a_zx;
    logic        [WIDTH-1:0] w_b_zx;
    logic        [WIDTH-1:0] w_a_ext;
    logic        [WIDTH-1:0] w_b_ext;
    pp_t                     w_dec;
    logic                    w_unused_dec;
    logic        [DW-1:0]    w_in_data;
    logic        [DW-1:0]    w_out_data;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_err_nx;
    logic        [CNT_W-1:0] w_cnt_nx;
    logic                    r_err;
    logic        [CNT_W-1:0] r_op_cnt;

    assign w_a_sx  = WIDTH'($signed(a_i));
    assign w_b_sx  = WIDTH'($signed(b_i));
    assign w_a_zx  = WIDTH'(a_i);
    assign w_b_zx  = WIDTH'(b_i);
    assign w_a_ext = sext_i ? w_a_sx : w_a_zx;
    assign w_b_ext = sext_i ? w_b_sx : w_b_zx;

    assign w_dec = preproc_decode(op_t'(op_i), PP_MAX_W'(w_a_ext), PP_MAX_W'(w_b_ext));
    // Bits above WIDTH are padding and intentionally left unconsumed.
    assign w_unused_dec = ^w_dec;
    assign w_in_data = {w_dec.a_mod[WIDTH-1:0], w_dec.b_mod[WIDTH-1:0], w_dec.cin, w_dec.cmp};

    skid_buffer #(
        .DW (DW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (w_in_ready),
        .in_data_i   (w_in_data),
        .out_valid_o (w_out_valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (w_out_data)
    );

    assign w_in_fire  = in_valid_i & w_in_ready;
    assign w_out_fire = w_out_valid & out_ready_i;

    // Error flag (set beats clear) and wrapping transfer counter.
    always_comb begin
        w_err_nx = r_err;
        w_cnt_nx = r_op_cnt;
        if (w_in_fire && w_dec.ill) begin
            w_err_nx = 1'b1;
        end else if (err_clr_i) begin
            w_err_nx = 1'b0;
        end else begin
            w_err_nx = r_err;
        end
        if (w_out_fire) begin
            w_cnt_nx = r_op_cnt + CNT_W'(1);
        end else begin
            w_cnt_nx = r_op_cnt;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err    <= 1'b0;
            r_op_cnt <= '0;
        end else begin
            r_err    <= w_err_nx;
            r_op_cnt <= w_cnt_nx;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign a_mod_o     = w_out_data[DW-1 -: WIDTH];
    assign b_mod_o     = w_out_data[WIDTH+1 -: WIDTH];
    assign cin_o       = w_out_data[1];
    assign cmp_o       = w_out_data[0];
    assign err_o       = r_err;
    assign op_cnt_o    = r_op_cnt;

endmodule
